cdb_arbiter: RTL
================

# cdb_arbiter

Arbiter and broadcast register for one common data bus (CDB). One instance drives the GPR CDB and one drives the FPR CDB. Each cycle it grants at most one requesting execution unit, including the load/store unit's `gpr_cdb_req`/`fpr_cdb_req`. One cycle later it broadcasts that unit's ROB tag and result as a `cdb_t` to the ROB, the register files and every reservation station. Arbitration is round-robin, so no unit starves.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesting units, 2..8. Index 0 is the highest-priority requester after reset.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `failure`  in  1: branch-misprediction flush from the ROB.
- `req[N_REQ]`  req_if (slave side)  —: per-unit handshake. `valid` is driven by the unit. `ready` is driven by this block.
- `tag[N_REQ]`  in  ROB_WIDTH: tag of the unit's pending result. Sampled in the grant cycle.
- `result[N_REQ]`  in  32: the unit's registered result. Valid in the cycle after its grant.
- `cdb`  out  cdb_t: `{valid, tag, data}` broadcast.

## Operation
- Unit contract:
  - A unit holds `valid` and `tag` stable until `ready`.
  - A handshake happens when `valid && ready` in cycle t.
  - The unit presents the data on `result` in cycle t+1, from its own output register.
- Grant logic is combinational within the cycle:
  - Search requesters starting at `rr_ptr` and wrapping modulo `N_REQ`.
  - The first one with `valid` wins, and `ready[w]=1`.
  - All other `ready` are 0.
  - `ready` depends on `valid` only, never on `result`.
- State:
  - `rr_ptr`: `$clog2(N_REQ)` bits.
  - `grant_v`: 1 bit.
  - `grant_idx`: `$clog2(N_REQ)` bits.
  - `grant_tag`: ROB_WIDTH bits.
- On a grant: `rr_ptr <= (w==N_REQ-1) ? 0 : w+1`, with explicit wrap so that non-power-of-two `N_REQ` works. With no grant, `rr_ptr` holds.
- `grant_v <= any_grant && !failure`, `grant_idx <= w`, `grant_tag <= tag[w]`.
- Output (combinational from state):
  - `cdb.valid = grant_v`
  - `cdb.tag = grant_tag`
  - `cdb.data = result[grant_idx]`
  - When `grant_v=0`, tag and data are don't-care, but are driven deterministically with no X-propagation: tag holds its last value, data selects index 0.
- Failure in cycle t:
  - All `ready` are forced to 0 in cycle t, so no unit loses a result it can no longer deliver.
  - `cdb.valid` in t+1 is 0.
  - The broadcast already on `cdb` in cycle t is left untouched; the ROB discards it.
- Reset in cycle t:
  - All `ready` are 0 in cycle t.
  - In t+1: `cdb.valid=0`, `rr_ptr=0`, `grant_idx=0`, `grant_tag=0`.
  - A grant made in t-1 still broadcasts in t; reset affects only t+1 onward.

## Timing
- Latency: handshake in cycle t, broadcast in t+1.
- Throughput: one grant per cycle. Back-to-back grants to the same unit are legal when it is the only requester.
- Reset values: `cdb.valid=0`, `cdb.tag=0`, `cdb.data=result[0]`, all `ready=0` while `reset` is high.
- Simultaneous `failure` and `reset`: reset takes precedence, with an identical outcome for `cdb.valid`.
- No combinational path from `result` to `ready`. No path from `cdb` back into grant logic.

## Structure
- `cdb_t` and `ROB_WIDTH` come from the shared definitions in `common.vh`; nothing new is added there.
- The round-robin search is a natural sub-module, `rr_pick`:
  - Parameter: `N_REQ`.
  - Inputs: `valid` vector and `ptr`.
  - Outputs: `any` and `idx`.
  - Purely combinational; reused by the issue stage.
- `cdb_arbiter` owns all registers.

## Test plan
- Single requester: after reset, `req[2].valid=1`, `tag[2]=5`, `result[2]=0x12345678` one cycle later. Expect `ready[2]=1` in t, and in t+1 `cdb={1,5,0x12345678}`, `rr_ptr=3`.
- All four requesters held valid for 8 cycles. Expect the grant order 0,1,2,3,0,1,2,3, with `cdb.valid=1` every cycle from t+1 and each tag matching its grant.
- Wrap and skip: `rr_ptr=3`, valid only on units 1 and 2. Expect unit 1 granted, then `rr_ptr=2`, then unit 2 granted.
- Failure: grant in t-1 and `failure=1` in t with unit 0 valid. Expect the t-1 grant broadcast in t, `ready[0]=0` in t, and `cdb.valid=0` in t+1. Unit 0 is granted in t+1 if still valid.
- Reset mid-stream: all units valid, `reset` pulsed in cycle t. Expect `ready=0` in t, `cdb.valid=0` in t+1, and unit 0 granted first once reset is low.
- `N_REQ=3`: requesters 0 and 2 continuously valid. Expect alternating grants 0,2,0,2 with `rr_ptr` never exceeding 2.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: ROB tag width, CDB payload
// struct and the round-robin pointer wrap helper.
package cdb_arbiter_pkg;

  localparam int ROB_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  // Successor of idx modulo n, written as an explicit wrap so non-power-of-two n works.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx == n - 32'd1) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of valid at or after ptr,
// wrapping modulo N_REQ. Shared with the issue stage.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W:0]   raw_s;
  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] cand_s;
  logic             hit_s;

  // Scan N_REQ candidates starting at ptr; the first valid one is latched into idx.
  always_comb begin
    any    = 1'b0;
    idx    = '0;
    raw_s  = '0;
    sum_s  = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      raw_s  = {1'b0, ptr} + (PTR_W+1)'(k);
      sum_s  = (raw_s >= (PTR_W+1)'(N_REQ)) ? (raw_s - (PTR_W+1)'(N_REQ)) : raw_s;
      cand_s = sum_s[PTR_W-1:0];
      hit_s  = !any && valid[cand_s];
      idx    = hit_s ? cand_s : idx;
      any    = any | hit_s;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for one common data bus: grants one requesting unit per
// cycle and broadcasts its ROB tag and registered result one cycle later.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  failure,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [ROB_WIDTH-1:0]  tag    [N_REQ],
  input  logic [DATA_WIDTH-1:0] result [N_REQ],
  output cdb_t                  cdb
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic                 grant_v_q,   grant_v_d;
  logic [PTR_W-1:0]     grant_idx_q, grant_idx_d;
  logic [ROB_WIDTH-1:0] grant_tag_q, grant_tag_d;

  logic             pick_any_s;
  logic [PTR_W-1:0] pick_idx_s;
  logic             grant_s;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .any   (pick_any_s),
    .idx   (pick_idx_s)
  );

  // A flush or reset in this cycle suppresses the handshake so no unit drops a result.
  assign grant_s = pick_any_s && !failure && !reset;

  // One-hot ready toward the winning unit.
  always_comb begin
    req_ready = '0;
    if (grant_s) begin
      req_ready[pick_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state: pointer advances past the winner; tag/idx hold when nothing is granted.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_v_d   = 1'b0;
    grant_idx_d = grant_idx_q;
    grant_tag_d = grant_tag_q;
    if (grant_s) begin
      rr_ptr_d    = PTR_W'(rr_next(32'(pick_idx_s), 32'(N_REQ)));
      grant_v_d   = 1'b1;
      grant_idx_d = pick_idx_s;
      grant_tag_d = tag[pick_idx_s];
    end else begin
      grant_v_d = 1'b0;
    end
  end

  // Grant state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      grant_v_q   <= 1'b0;
      grant_idx_q <= '0;
      grant_tag_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_v_q   <= grant_v_d;
      grant_idx_q <= grant_idx_d;
      grant_tag_q <= grant_tag_d;
    end
  end

  // Broadcast; idle cycles select result[0] so data never floats to X.
  always_comb begin
    cdb.valid = grant_v_q;
    cdb.tag   = grant_tag_q;
    if (grant_v_q) begin
      cdb.data = result[grant_idx_q];
    end else begin
      cdb.data = result[0];
    end
  end

endmodule
